// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester ports A/B and RAM-side signals for ram_port_arbiter.
// master = requesters plus RAM model, slave = the arbiter itself.
interface ram_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata,
        input  busy, owner
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata,
        output busy, owner
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between port A (CPU) and port B (loader/debug): grant, one-cycle
// strobe, fixed MEM_LAT wait, one-cycle ack. Define ARB_ROUND_ROBIN_EN for round-robin ties.
module ram_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("ram_port_arbiter: MEM_LAT must be in 1..15");
    end

    state_t            stateReg;
    logic [3:0]        waitCnt;
    logic              ownerReg;
    logic              isWriteReg;
    logic              busyReg;
    logic              memReadReg;
    logic              memWriteReg;
    logic [ADDR_W-1:0] memAddrReg;
    logic [DATA_W-1:0] memWdataReg;
    logic [1:0]        ackReg;
    logic [DATA_W-1:0] rdataReg [2];

    logic              anyReq;
    logic              grantB;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    assign anyReq = bus.a_req | bus.b_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when B was the most recent grant; a tie goes to whichever port was not served last.
    logic lastB;
    assign grantB = (bus.a_req & bus.b_req) ? ~lastB : bus.b_req;
`else
    assign grantB = bus.b_req & ~bus.a_req;
`endif

    assign selWe    = grantB ? bus.b_we    : bus.a_we;
    assign selAddr  = grantB ? bus.b_addr  : bus.a_addr;
    assign selWdata = grantB ? bus.b_wdata : bus.a_wdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg    <= S_IDLE;
            waitCnt     <= '0;
            ownerReg    <= 1'b0;
            isWriteReg  <= 1'b0;
            busyReg     <= 1'b0;
            memReadReg  <= 1'b0;
            memWriteReg <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            ackReg      <= '0;
            rdataReg[0] <= '0;
            rdataReg[1] <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            lastB       <= 1'b1;
`endif
        end else begin
            case (stateReg)
                S_IDLE: begin
                    if (anyReq) begin
                        memAddrReg  <= selAddr;
                        memWdataReg <= selWdata;
                        ownerReg    <= grantB;
                        isWriteReg  <= selWe;
                        memReadReg  <= ~selWe;
                        memWriteReg <= selWe;
                        busyReg     <= 1'b1;
                        stateReg    <= S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        lastB       <= grantB;
`endif
                    end
                end
                S_ISSUE: begin
                    memReadReg  <= 1'b0;
                    memWriteReg <= 1'b0;
                    waitCnt     <= WAIT_LOAD;
                    stateReg    <= S_WAIT;
                end
                S_WAIT: begin
                    if (waitCnt == 4'd0) begin
                        // Writes leave the owner's last read data untouched.
                        if (!isWriteReg) begin
                            rdataReg[ownerReg] <= bus.mem_rdata;
                        end
                        ackReg[ownerReg] <= 1'b1;
                        stateReg         <= S_ACK;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                S_ACK: begin
                    ackReg   <= '0;
                    busyReg  <= 1'b0;
                    stateReg <= S_IDLE;
                end
                default: begin
                    stateReg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.a_ack     = ackReg[0];
    assign bus.b_ack     = ackReg[1];
    assign bus.a_rdata   = rdataReg[0];
    assign bus.b_rdata   = rdataReg[1];
    assign bus.mem_addr  = memAddrReg;
    assign bus.mem_wdata = memWdataReg;
    assign bus.mem_read  = memReadReg;
    assign bus.mem_write = memWriteReg;
    assign bus.busy      = busyReg;
    assign bus.owner     = ownerReg;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: one instance with MEM_LAT=1 (index 0), one with MEM_LAT=3 (index 1),
// each with its own latency-accurate RAM model; acks are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    typedef struct {
        int          dut;
        bit          port;
        logic [31:0] rdata;
        int          ackCyc;
    } exp_t;

    typedef struct {
        int          dut;
        bit          port;
        bit          we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
    } vec_t;

    logic clk = 1'b0;
    logic resetN;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ackSeen = 0;
    int   writeCount [2];
    int   lat [2] = '{1, 3};
    exp_t sbQ [$];

    logic [1:0]  aReq, aWe, bReq, bWe;
    logic [8:0]  aAddr [2];
    logic [8:0]  bAddr [2];
    logic [31:0] aWdata [2];
    logic [31:0] bWdata [2];
    logic [1:0]  ackA, ackB, memRd, memWr, busyV, ownerV;
    logic [8:0]  memAddr [2];
    logic [31:0] memWdata [2];
    logic [31:0] rdA [2];
    logic [31:0] rdB [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ramInit(input logic [8:0] a);
        if (a == 9'h010) return 32'hDEADBEEF;
        return {16'hA5C3, 7'b0, a};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : 3;

        ram_port_arbiter_if #(.DATA_W(32), .ADDR_W(9)) bus ();

        ram_port_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(L)) dut (
            .clock (clk),
            .reset (resetN),
            .bus   (bus)
        );

        assign bus.a_req   = aReq[gi];
        assign bus.a_we    = aWe[gi];
        assign bus.a_addr  = aAddr[gi];
        assign bus.a_wdata = aWdata[gi];
        assign bus.b_req   = bReq[gi];
        assign bus.b_we    = bWe[gi];
        assign bus.b_addr  = bAddr[gi];
        assign bus.b_wdata = bWdata[gi];

        assign ackA[gi]     = bus.a_ack;
        assign ackB[gi]     = bus.b_ack;
        assign rdA[gi]      = bus.a_rdata;
        assign rdB[gi]      = bus.b_rdata;
        assign memRd[gi]    = bus.mem_read;
        assign memWr[gi]    = bus.mem_write;
        assign memAddr[gi]  = bus.mem_addr;
        assign memWdata[gi] = bus.mem_wdata;
        assign busyV[gi]    = bus.busy;
        assign ownerV[gi]   = bus.owner;

        // RAM model: data appears exactly L cycles after the strobe cycle, garbage otherwise.
        logic [31:0] mem [512];
        bit   [511:0] written;
        logic [31:0] pipe [L];
        always @(posedge clk) begin
            if (bus.mem_write) begin
                mem[bus.mem_addr]     <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end
            pipe[0] <= bus.mem_read ? (written[bus.mem_addr] ? mem[bus.mem_addr] : ramInit(bus.mem_addr))
                                    : 32'hBAD0BAD0;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign bus.mem_rdata = pipe[L-1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input bit port, input bit req, input bit we,
                         input logic [8:0] addr, input logic [31:0] wdata);
        if (port) begin
            bReq[d] = req; bWe[d] = we; bAddr[d] = addr; bWdata[d] = wdata;
        end else begin
            aReq[d] = req; aWe[d] = we; aAddr[d] = addr; aWdata[d] = wdata;
        end
    endtask

    task automatic expect_ack(input int d, input bit port, input logic [31:0] rdata, input int ackCyc);
        exp_t e;
        e.dut = d; e.port = port; e.rdata = rdata; e.ackCyc = ackCyc;
        sbQ.push_back(e);
    endtask

    task automatic waitAcks(input int target, input string name);
        for (int i = 0; i < 200 && ackSeen < target; i++) step();
        if (ackSeen < target) failNow(name);
    endtask

    // One complete access: request, strobe check, busy until ack, release, then idle check.
    task automatic doAccess(input vec_t v);
        int wc0;
        bit got;
        expect_ack(v.dut, v.port, v.expRdata, cyc + lat[v.dut] + 2);
        wc0 = writeCount[v.dut];
        drive(v.dut, v.port, 1'b1, v.we, v.addr, v.wdata);
        step();
        check("strobe", {memRd[v.dut], memWr[v.dut]}, {~v.we, v.we});
        check("mem_addr", memAddr[v.dut], v.addr);
        if (v.we) check("mem_wdata", memWdata[v.dut], v.wdata);
        check("owner", ownerV[v.dut], v.port);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            check("busy", busyV[v.dut], 1);
            if (v.port ? ackB[v.dut] : ackA[v.dut]) got = 1;
            else step();
        end
        if (!got) failNow("ack_timeout");
        drive(v.dut, v.port, 1'b0, v.we, v.addr, v.wdata);
        step();
        check("busy_after_ack", busyV[v.dut], 0);
        check("write_pulses", 64'(writeCount[v.dut] - wc0), v.we ? 64'd1 : 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (memWr[d] === 1'b1) writeCount[d]++;
            if (ackA[d] === 1'b1 || ackB[d] === 1'b1) begin
                ackSeen++;
                check("ack_onehot", 64'(ackA[d] & ackB[d]), 64'd0);
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ack_unexpected: dut=%0d a_ack=%b b_ack=%b required none (cycle %0d)",
                             d, ackA[d], ackB[d], cyc);
                end else begin
                    e = sbQ.pop_front();
                    check("ack_dut", 64'(d), 64'(e.dut));
                    check("ack_port", ackB[d], e.port);
                    check("ack_rdata", ackB[d] ? rdB[d] : rdA[d], e.rdata);
                    check("ack_cycle", 64'(cyc), 64'(e.ackCyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [11];
        int   s;
        int   base;

        vecs[0]  = '{0, 1'b0, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{0, 1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'h00000000};
        vecs[2]  = '{0, 1'b0, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
        vecs[3]  = '{0, 1'b1, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1, 1'b0, 1'b0, 9'h000, 32'h0,        32'hA5C30000};
        vecs[5]  = '{1, 1'b0, 1'b0, 9'h001, 32'h0,        32'hA5C30001};
        vecs[6]  = '{1, 1'b0, 1'b0, 9'h002, 32'h0,        32'hA5C30002};
        vecs[7]  = '{1, 1'b1, 1'b1, 9'h003, 32'hCAFEF00D, 32'h00000000};
        vecs[8]  = '{1, 1'b1, 1'b0, 9'h003, 32'h0,        32'hCAFEF00D};
        vecs[9]  = '{1, 1'b0, 1'b1, 9'h000, 32'h0BADF00D, 32'hA5C30002};
        vecs[10] = '{1, 1'b1, 1'b0, 9'h000, 32'h0,        32'h0BADF00D};

        aReq = '0; aWe = '0; bReq = '0; bWe = '0;
        for (int d = 0; d < 2; d++) begin
            aAddr[d] = '0; bAddr[d] = '0; aWdata[d] = '0; bWdata[d] = '0;
            writeCount[d] = 0;
        end
        resetN = 1'b1;
        #1 resetN = 1'b0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            check("reset_ctrl", {ackA[d], ackB[d], memRd[d], memWr[d], busyV[d], ownerV[d]}, 64'd0);
            check("reset_rdata", {rdA[d], rdB[d]}, 64'd0);
            check("reset_mem", {memAddr[d], memWdata[d]}, 64'd0);
        end
        resetN = 1'b1;
        step();

        for (int i = 0; i < 11; i++) doAccess(vecs[i]);

        for (int i = 0; i < 20; i++) begin
            step();
            for (int d = 0; d < 2; d++)
                check("idle_ctrl", {memRd[d], memWr[d], busyV[d], ackA[d], ackB[d]}, 64'd0);
            check("idle_addr0", memAddr[0], 9'h010);
            check("idle_addr1", memAddr[1], 9'h000);
        end

        // Both ports held high on the MEM_LAT=1 instance; B was served last.
        s = cyc;
        base = ackSeen;
`ifdef ARB_ROUND_ROBIN_EN
        expect_ack(0, 1'b0, 32'hA5C30005, s + 3);
        expect_ack(0, 1'b1, 32'hA5C30006, s + 7);
        expect_ack(0, 1'b0, 32'hA5C30005, s + 11);
        expect_ack(0, 1'b1, 32'hA5C30006, s + 15);
`else
        for (int k = 0; k < 4; k++) expect_ack(0, 1'b0, 32'hA5C30005, s + 3 + 4 * k);
        expect_ack(0, 1'b1, 32'hA5C30006, s + 19);
`endif
        drive(0, 1'b0, 1'b1, 1'b0, 9'h005, 32'h0);
        drive(0, 1'b1, 1'b1, 1'b0, 9'h006, 32'h0);
        waitAcks(base + 4, "tie_acks");
        drive(0, 1'b0, 1'b0, 1'b0, 9'h005, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
        drive(0, 1'b1, 1'b0, 1'b0, 9'h006, 32'h0);
`else
        waitAcks(base + 5, "tie_b_after_a");
        drive(0, 1'b1, 1'b0, 1'b0, 9'h006, 32'h0);
`endif
        step();

        // Reset during WAIT on the MEM_LAT=3 instance; port B holds its request throughout.
        drive(1, 1'b1, 1'b1, 1'b0, 9'h007, 32'h0);
        step();
        step();
        step();
        check("pre_reset_busy_owner", {busyV[1], ownerV[1]}, 2'b11);
        #2 resetN = 1'b0;
        #1;
        check("reset_wait_async", {memRd[1], busyV[1], ownerV[1], ackB[1]}, 64'd0);
        step();
        resetN = 1'b1;
        expect_ack(1, 1'b1, 32'hA5C30007, cyc + 5);
        base = ackSeen;
        waitAcks(base + 1, "reserve_after_reset_b");
        drive(1, 1'b1, 1'b0, 1'b0, 9'h007, 32'h0);
        step();

        // Reset while the read strobe is visible: the strobe must drop without waiting for an edge.
        drive(1, 1'b0, 1'b1, 1'b0, 9'h008, 32'h0);
        step();
        check("pre_reset_strobe", memRd[1], 1);
        #2 resetN = 1'b0;
        #1;
        check("reset_issue_async", {memRd[1], memWr[1], busyV[1], memAddr[1]}, 64'd0);
        step();
        resetN = 1'b1;
        expect_ack(1, 1'b0, 32'hA5C30008, cyc + 5);
        base = ackSeen;
        waitAcks(base + 1, "reserve_after_reset_a");
        drive(1, 1'b0, 1'b0, 1'b0, 9'h008, 32'h0);
        step();

        for (int i = 0; i < 10; i++) step();
        check("scoreboard_empty", 64'(sbQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port RAM between two requesters. Port A is the CPU datapath (MAR/MDR path driven by the control unit). Port B is the loader/debug port.
- Sequences each access: arbitrate, issue a one-cycle read/write strobe, wait a fixed latency, return read data with a one-cycle ack.
- Sits between the requesters and the RAM. It drives the RAM address, write data and read/write strobes.

Parameters:
- DATA_W, 32, data width of RAM words and of both ports.
- ADDR_W, 9, RAM word address width (512 words).
- MEM_LAT, 1, cycles from strobe assertion to mem_rdata valid; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held high until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read; stable while a_req is high.
- a_addr  in  ADDR_W  port A word address; stable while a_req is high.
- a_wdata  in  DATA_W  port A write data; stable while a_req is high.
- a_ack  out  1  port A one-cycle completion pulse.
- a_rdata  out  DATA_W  port A read data; valid while a_ack is high, then held.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high from grant until the ack cycle, inclusive.
- owner  out  1  port currently or last granted (0 = A, 1 = B).

Behaviour:
- All outputs are registered.
- Reset values: a_ack = b_ack = 0; a_rdata = b_rdata = 0; mem_addr = 0; mem_wdata = 0; mem_read = mem_write = 0; busy = 0; owner = 0; state = IDLE; wait counter = 0.
- Reset asserted mid-transaction: abandon the access immediately. Strobes drop asynchronously, no ack is ever issued for it, and the FSM re-samples requests after reset releases.
- FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - No request: stay in IDLE, busy = 0.
  - Request present: latch the winner's addr/we/wdata into mem_addr/mem_wdata, set owner, go to ISSUE.
  - On the same edge, set mem_read = ~we or mem_write = we, and set busy = 1.
- ISSUE (one cycle, strobe visible): clear the strobe at the end of the cycle and load the wait counter with MEM_LAT-1.
  - If MEM_LAT = 1, go directly to WAIT with counter 0.
- WAIT: decrement the counter each cycle. When the counter is 0:
  - capture mem_rdata into the owner's rdata (reads only; writes leave rdata unchanged);
  - pulse the owner's ack;
  - go to ACK.
- ACK (one cycle): owner's ack = 1, busy = 1. Next state IDLE; ack and busy clear on the exit edge.
- Timing: strobe in cycle T, mem_rdata sampled at the end of cycle T+MEM_LAT, ack in cycle T+MEM_LAT+1.
  - Total request-to-ack latency = MEM_LAT+2 cycles from the first cycle req is seen in IDLE.
- Requester rule: deassert req on the edge ending the ack cycle. A req high in IDLE is always a new transaction, so back-to-back requesters present new addr/data in the cycle after ack.
- The non-owner's ack stays 0 throughout. Its req may stay high and is served in a later IDLE.
- Arbitration (feature off): fixed priority. A wins over B when both are high in IDLE.
- mem_addr/mem_wdata hold their last value when idle. Strobes are never both high.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - A last-served pointer is updated when a grant is made.
  - On simultaneous requests, grant the port not served last.
  - The pointer resets to "B last", so A wins the first tie.
  - A lone request is always granted.
- Undefined: fixed A-over-B priority as above; no pointer state.

Test Plan:
- Single read, MEM_LAT=1:
  - Stimulus: RAM[0x010] = 0xDEADBEEF; a_req = 1, a_we = 0, a_addr = 0x010 in cycle 0.
  - Required: mem_read = 1 and mem_addr = 0x010 in cycle 1; a_ack = 1 with a_rdata = 0xDEADBEEF in cycle 3; busy high in cycles 1-3; b_ack stays 0.
- Port B write, then port A read:
  - Stimulus: b_req with b_we = 1, b_addr = 0x1FF, b_wdata = 0x12345678; after b_ack, a_req with a read of 0x1FF.
  - Required: mem_write pulses exactly once with mem_wdata = 0x12345678; a_rdata = 0x12345678; owner = 1, then 0.
- Simultaneous requests:
  - Stimulus: a_req and b_req both held high for repeated transactions.
  - Required, feature off: A is served for every transaction while a_req stays high.
  - Required, ARB_ROUND_ROBIN_EN: grants alternate A, B, A, B; a_ack and b_ack are never high together.
- Reset mid-access:
  - Stimulus: MEM_LAT=3; assert reset low during WAIT.
  - Required: mem_read = 0, busy = 0, owner = 0 immediately; no ack after release; a held req is re-served from IDLE with full latency 5.
- MEM_LAT=3 back-to-back:
  - Stimulus: port A issues reads of 0x000, 0x001, 0x002 with the new address presented the cycle after each ack.
  - Required: acks 6 cycles apart; rdata matches RAM contents each time.
- Idle:
  - Stimulus: no requests for 20 cycles.
  - Required: strobes 0; mem_addr holds its last value; busy = 0.
